uart_rx: RTL



---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module     : uart_rx_if
//  Description: Received-byte stream (valid/ready/data) plus the two error
//               pulses of the UART receiver, bundled for module ports.
//  Revision   : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       frame_err;
  logic       overrun;

  // Receiver side: produces the stream and the error pulses
  modport master (
    output valid,
    output data,
    output frame_err,
    output overrun,
    input  ready
  );

  // Consumer side: accepts bytes and observes the error pulses
  modport slave (
    input  valid,
    input  data,
    input  frame_err,
    input  overrun,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module     : uart_rx
//  Description: 8N1 asynchronous serial receiver, LSB first, idle-high line.
//               One bit period is clkdiv+1 clk cycles. The rx pin is
//               synchronised, each bit is sampled at mid-period and the byte
//               is offered through a one-entry holding register on a
//               valid/ready stream. Framing errors and overruns are reported
//               as single-cycle pulses.
//  Revision   : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int SYNC_STAGES = 2   // rx synchroniser depth, at least 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] clkdiv,
  input  wire logic        rx,
  uart_rx_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchroniser chain; stage 0 captures the pin, the last stage is rx_s
  logic [SYNC_STAGES-1:0] r_sync;

  state_t      r_state;
  logic [31:0] r_clkcnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;

  logic        r_valid;
  logic [7:0]  r_data;
  logic        r_frame_err;
  logic        r_overrun;

  logic        w_rx_s;
  logic        w_cnt_zero;
  logic        w_deliver;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_cnt_zero = (r_clkcnt == 32'd0);
  // A byte is complete when the stop bit is sampled high
  assign w_deliver  = (r_state == S_STOP) && w_cnt_zero && w_rx_s;

  assign bus.valid     = r_valid;
  assign bus.data      = r_data;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

  // Shift the asynchronous pin through the synchroniser; preset to idle-high
  // so a line that is already idle after reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  // Frame state machine with the holding register and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clkcnt    <= 32'd0;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'd0;
      r_valid     <= 1'b0;
      r_data      <= 8'd0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Error outputs are pulses; they fall unless re-raised below
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Holding register: a new byte is taken if the slot is empty or is
      // being drained in this same cycle, otherwise the new byte is lost
      if (w_deliver) begin
        if (!r_valid || bus.ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Falling edge seen: wait half a bit to land mid start bit
          if (!w_rx_s) begin
            r_clkcnt <= clkdiv >> 1;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (w_cnt_zero) begin
            if (!w_rx_s) begin
              r_clkcnt <= clkdiv;
              r_bitcnt <= 3'd0;
              r_state  <= S_DATA;
            end else begin
              // Low pulse too short to be a start bit
              r_state <= S_IDLE;
            end
          end else begin
            r_clkcnt <= r_clkcnt - 32'd1;
          end
        end

        S_DATA: begin
          if (w_cnt_zero) begin
            // LSB arrives first, so shifting right leaves it in bit 0
            r_shift  <= {w_rx_s, r_shift[7:1]};
            r_clkcnt <= clkdiv;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clkcnt <= r_clkcnt - 32'd1;
          end
        end

        S_STOP: begin
          if (w_cnt_zero) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_clkcnt <= r_clkcnt - 32'd1;
          end
        end

        S_BREAK: begin
          // A held-low line reports one framing error, then waits for idle
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
